// File: rtl/neighbor_table_writer_if.sv
// -----------------------------------------------------------------------------
// neighbor_table_writer_if
//
// Bundles the request/response handshake and the shared-memory port of the
// neighbor Q-table writer.
//
//   start, nb_id, nb_qvalue        request (sampled while the writer is idle)
//   busy, done, dropped            status (done is a one-cycle pulse)
//   best_id, best_qvalue           best (lowest Q) entry after the update
//   neighbor_count                 entry count after the update
//   address, wr_en, mem_data_in    memory command (all zero while idle)
//   mem_data_out                   memory read data, one cycle after address
//
// Modports: slave = the writer, master = its requester plus the memory.
// -----------------------------------------------------------------------------
interface neighbor_table_writer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  start;
    logic [WORD_WIDTH-1:0] nb_id;
    logic [WORD_WIDTH-1:0] nb_qvalue;
    logic                  busy;
    logic                  done;
    logic                  dropped;
    logic [WORD_WIDTH-1:0] best_id;
    logic [WORD_WIDTH-1:0] best_qvalue;
    logic [WORD_WIDTH-1:0] neighbor_count;
    logic [WORD_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] mem_data_in;
    logic [WORD_WIDTH-1:0] mem_data_out;

    modport slave (
        input  start, nb_id, nb_qvalue, mem_data_out,
        output busy, done, dropped, best_id, best_qvalue, neighbor_count,
               address, wr_en, mem_data_in
    );

    modport master (
        output start, nb_id, nb_qvalue, mem_data_out,
        input  busy, done, dropped, best_id, best_qvalue, neighbor_count,
               address, wr_en, mem_data_in
    );
endinterface

// File: rtl/neighbor_table_writer.sv
// -----------------------------------------------------------------------------
// neighbor_table_writer
//
// Upserts one (neighbor ID, Q-value) pair into the neighbor table held in
// shared memory. The table is scanned entry by entry: the first entry whose
// ID matches gets its Q-value overwritten; if none matches, the pair is
// appended and the count word rewritten (count last, so an interrupted append
// never exposes a half-written entry), or the update is dropped when the
// table is full. The lowest Q-value and its ID are recomputed during the scan.
//
// Memory layout (byte addresses, 16-bit words):
//   TABLE_BASE        count
//   TABLE_BASE+2+4i   entry i ID
//   TABLE_BASE+4+4i   entry i Q-value
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high
//   bus     neighbor_table_writer_if.slave (request, status, memory port)
//
// Every output is a register loaded from the next-state decode, so the memory
// command appears in the same cycle as the state that owns it.
// -----------------------------------------------------------------------------
module neighbor_table_writer #(
    parameter int                    WORD_WIDTH    = 16,
    parameter logic [WORD_WIDTH-1:0] TABLE_BASE    = 16'h0100,
    parameter int                    MAX_NEIGHBORS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    neighbor_table_writer_if.slave    bus
);
    localparam int                CNT_W = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [CNT_W-1:0]  MAX_N = CNT_W'(MAX_NEIGHBORS);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] RD_COUNT   = 4'd1;
    localparam logic [3:0] LOAD_COUNT = 4'd2;
    localparam logic [3:0] RD_ID      = 4'd3;
    localparam logic [3:0] RD_Q       = 4'd4;
    localparam logic [3:0] CMP        = 4'd5;
    localparam logic [3:0] WR_Q       = 4'd6;
    localparam logic [3:0] APPEND_ID  = 4'd7;
    localparam logic [3:0] APPEND_Q   = 4'd8;
    localparam logic [3:0] WR_COUNT   = 4'd9;
    localparam logic [3:0] DONE       = 4'd10;

    logic [3:0]            state,    state_nx;
    logic [WORD_WIDTH-1:0] id_r,     id_nx;
    logic [WORD_WIDTH-1:0] q_r,      q_nx;
    logic                  match,    match_nx;
    logic [CNT_W-1:0]      n_r,      n_nx;
    logic [CNT_W-1:0]      idx,      idx_nx;
    logic [WORD_WIDTH-1:0] entry_id, entry_id_nx;
    logic [WORD_WIDTH-1:0] best_id,  best_id_nx;
    logic [WORD_WIDTH-1:0] best_q,   best_q_nx;
    logic                  dropped,  dropped_nx;
    logic [WORD_WIDTH-1:0] count,    count_nx;
    logic [WORD_WIDTH-1:0] address,  address_nx;
    logic                  wr_en,    wr_en_nx;
    logic [WORD_WIDTH-1:0] wdata,    wdata_nx;
    logic                  busy,     busy_nx;
    logic                  done,     done_nx;

    logic [CNT_W-1:0]      idx_inc;
    logic                  more;
    logic [3:0]            tail_state;
    logic                  tail_drop;
    logic                  cand_take;
    logic [WORD_WIDTH-1:0] cand_id;
    logic [WORD_WIDTH-1:0] cand_q;

    function automatic logic [WORD_WIDTH-1:0] id_addr(input logic [CNT_W-1:0] i);
        return TABLE_BASE + WORD_WIDTH'(2) + (WORD_WIDTH'(i) << 2);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] q_addr(input logic [CNT_W-1:0] i);
        return TABLE_BASE + WORD_WIDTH'(4) + (WORD_WIDTH'(i) << 2);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch to hold it.
        state_nx    = state;
        id_nx       = id_r;
        q_nx        = q_r;
        match_nx    = match;
        n_nx        = n_r;
        idx_nx      = idx;
        entry_id_nx = entry_id;
        best_id_nx  = best_id;
        best_q_nx   = best_q;
        dropped_nx  = dropped;
        count_nx    = count;
        cand_take   = 1'b0;
        cand_id     = entry_id;
        cand_q      = bus.mem_data_out;

        // The NEXT/TAIL steps cost no cycle, so they are resolved here and
        // folded into whichever state finishes an entry.
        idx_inc    = idx + CNT_W'(1);
        more       = idx_inc < n_r;
        tail_drop  = !match && (n_r == MAX_N);
        tail_state = (match || tail_drop) ? DONE : APPEND_ID;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    id_nx      = bus.nb_id;
                    q_nx       = bus.nb_qvalue;
                    match_nx   = 1'b0;
                    best_id_nx = '0;
                    best_q_nx  = '1;
                    dropped_nx = 1'b0;
                    state_nx   = RD_COUNT;
                end
            end
            RD_COUNT: state_nx = LOAD_COUNT;
            LOAD_COUNT: begin
                // A corrupt count above capacity is clamped, not repaired.
                n_nx     = (bus.mem_data_out > WORD_WIDTH'(MAX_NEIGHBORS)) ?
                           MAX_N : CNT_W'(bus.mem_data_out);
                count_nx = WORD_WIDTH'(n_nx);
                idx_nx   = '0;
                state_nx = (n_nx == '0) ? APPEND_ID : RD_ID;
            end
            RD_ID: state_nx = RD_Q;
            RD_Q: begin
                entry_id_nx = bus.mem_data_out;
                state_nx    = CMP;
            end
            CMP: begin
                // Only the first matching entry is rewritten; later duplicates
                // compete for best with their stored Q.
                if (entry_id == id_r && !match) begin
                    match_nx = 1'b1;
                    state_nx = WR_Q;
                end else begin
                    cand_take = 1'b1;
                    idx_nx    = idx_inc;
                    state_nx  = more ? RD_ID : tail_state;
                    if (!more) dropped_nx = tail_drop;
                end
            end
            WR_Q: begin
                cand_take = 1'b1;
                cand_q    = q_r;
                idx_nx    = idx_inc;
                state_nx  = more ? RD_ID : DONE;
            end
            APPEND_ID: begin
                cand_take = 1'b1;
                cand_id   = id_r;
                cand_q    = q_r;
                state_nx  = APPEND_Q;
            end
            APPEND_Q: state_nx = WR_COUNT;
            WR_COUNT: begin
                count_nx = WORD_WIDTH'(n_r) + WORD_WIDTH'(1);
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Strict '<' keeps the earliest entry on ties.
        if (cand_take && (cand_q < best_q)) begin
            best_id_nx = cand_id;
            best_q_nx  = cand_q;
        end

        address_nx = '0;
        wr_en_nx   = 1'b0;
        wdata_nx   = '0;
        case (state_nx)
            RD_COUNT:  address_nx = TABLE_BASE;
            RD_ID:     address_nx = id_addr(idx_nx);
            RD_Q:      address_nx = q_addr(idx);
            WR_Q: begin
                address_nx = q_addr(idx);
                wr_en_nx   = 1'b1;
                wdata_nx   = q_r;
            end
            APPEND_ID: begin
                address_nx = id_addr(n_nx);
                wr_en_nx   = 1'b1;
                wdata_nx   = id_nx;
            end
            APPEND_Q: begin
                address_nx = q_addr(n_r);
                wr_en_nx   = 1'b1;
                wdata_nx   = q_r;
            end
            WR_COUNT: begin
                address_nx = TABLE_BASE;
                wr_en_nx   = 1'b1;
                wdata_nx   = WORD_WIDTH'(n_r) + WORD_WIDTH'(1);
            end
            default: ;
        endcase
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            id_r     <= '0;
            q_r      <= '0;
            match    <= 1'b0;
            n_r      <= '0;
            idx      <= '0;
            entry_id <= '0;
            best_id  <= '0;
            best_q   <= '1;
            dropped  <= 1'b0;
            count    <= '0;
            address  <= '0;
            wr_en    <= 1'b0;
            wdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_nx;
            id_r     <= id_nx;
            q_r      <= q_nx;
            match    <= match_nx;
            n_r      <= n_nx;
            idx      <= idx_nx;
            entry_id <= entry_id_nx;
            best_id  <= best_id_nx;
            best_q   <= best_q_nx;
            dropped  <= dropped_nx;
            count    <= count_nx;
            address  <= address_nx;
            wr_en    <= wr_en_nx;
            wdata    <= wdata_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    assign bus.address        = address;
    assign bus.wr_en          = wr_en;
    assign bus.mem_data_in    = wdata;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.dropped        = dropped;
    assign bus.best_id        = best_id;
    assign bus.best_qvalue    = best_q;
    assign bus.neighbor_count = count;
endmodule

// File: tb/tb_neighbor_table_writer.sv
// -----------------------------------------------------------------------------
// tb_neighbor_table_writer
//
// Drives directed upserts into neighbor_table_writer against a behavioural
// one-cycle-latency memory. Each operation pushes its expected memory writes
// and its expected completion record (done cycle, dropped, best, count) into
// queues; independent monitors pop and compare whenever the DUT writes memory
// or pulses done.
// -----------------------------------------------------------------------------
module tb_neighbor_table_writer;
    localparam int W = 16;

    typedef struct {
        string       name;
        int unsigned done_cycle;
        logic        dropped;
        logic [W-1:0] best_id;
        logic [W-1:0] best_q;
        logic [W-1:0] count;
        int          writes_left;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    neighbor_table_writer_if #(.WORD_WIDTH(W)) bus ();

    neighbor_table_writer #(
        .WORD_WIDTH   (W),
        .TABLE_BASE   (16'h0100),
        .MAX_NEIGHBORS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    wr_t         exp_wr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    int unsigned cycle = 0;

    logic [W-1:0] mem [0:1023];
    logic         pl_we = 1'b0;
    logic [9:0]   pl_addr = '0;
    logic [W-1:0] pl_data = '0;

    always @(posedge clock) cycle++;

    // Memory: one-cycle read latency, writes at the edge while wr_en is high.
    always @(posedge clock) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (bus.wr_en)
            mem[bus.address[10:1]] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.address[10:1]];
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor
    always @(negedge clock) begin : wmon
        wr_t e;
        if (!reset && bus.wr_en) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.address, bus.mem_data_in);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", 32'(bus.address), 32'(e.addr));
                check("wr_data", 32'(bus.mem_data_in), 32'(e.data));
            end
        end
    end

    // Completion monitor
    always @(negedge clock) begin : dmon
        exp_t e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: at cycle %0d, expected no done", cycle);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_done_cycle"}, 32'(cycle), 32'(e.done_cycle));
                check({e.name, "_dropped"}, 32'(bus.dropped), 32'(e.dropped));
                check({e.name, "_best_id"}, 32'(bus.best_id), 32'(e.best_id));
                check({e.name, "_best_q"}, 32'(bus.best_qvalue), 32'(e.best_q));
                check({e.name, "_count"}, 32'(bus.neighbor_count), 32'(e.count));
                check({e.name, "_writes_left"}, 32'(exp_wr_q.size()), 32'(e.writes_left));
            end
            done_count++;
        end
    end

    task automatic write_word(input logic [W-1:0] addr, input logic [W-1:0] data);
        @(negedge clock);
        pl_we   = 1'b1;
        pl_addr = addr[10:1];
        pl_data = data;
    endtask

    task automatic clear_table(input logic [W-1:0] count);
        for (int a = 0; a < 18; a++) write_word(W'(16'h0100 + 2 * a), '0);
        write_word(16'h0100, count);
    endtask

    task automatic put_entry(input int i, input logic [W-1:0] id, input logic [W-1:0] q);
        write_word(W'(16'h0102 + 4 * i), id);
        write_word(W'(16'h0104 + 4 * i), q);
    endtask

    task automatic exp_wr(input logic [W-1:0] addr, input logic [W-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_wr_q.push_back(e);
    endtask

    task automatic push_exp(input string name, input int unsigned done_cycle,
                            input logic drop, input logic [W-1:0] bid,
                            input logic [W-1:0] bq, input logic [W-1:0] cnt,
                            input int wl);
        exp_t e;
        e.name        = name;
        e.done_cycle  = done_cycle;
        e.dropped     = drop;
        e.best_id     = bid;
        e.best_q      = bq;
        e.count       = cnt;
        e.writes_left = wl;
        exp_q.push_back(e);
    endtask

    task automatic wait_dones(input string name, input int target);
        for (int t = 0; t < 200 && done_count < target; t++) @(negedge clock);
        if (done_count < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: saw %0d dones, expected %0d", name, done_count, target);
            exp_q.delete();
            exp_wr_q.delete();
        end
        @(negedge clock);
    endtask

    // One upsert; k is the expected done cycle counted from the start-sampling edge.
    task automatic run_op(input string name, input logic [W-1:0] id, input logic [W-1:0] q,
                          input int k, input logic drop, input logic [W-1:0] bid,
                          input logic [W-1:0] bq, input logic [W-1:0] cnt,
                          input bit glitch);
        int target;
        target = done_count + 1;
        @(negedge clock);
        pl_we         = 1'b0;
        bus.nb_id     = id;
        bus.nb_qvalue = q;
        bus.start     = 1'b1;
        push_exp(name, cycle + k, drop, bid, bq, cnt, 0);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
        if (glitch) begin
            repeat (3) @(negedge clock);
            bus.nb_id     = 16'd55;
            bus.nb_qvalue = 16'd0;
            bus.start     = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
        end
        wait_dones(name, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        bus.start     = 1'b0;
        bus.nb_id     = '0;
        bus.nb_qvalue = '0;

        repeat (3) @(negedge clock);
        check("rst_address", 32'(bus.address), 32'h0);
        check("rst_wr_en", 32'(bus.wr_en), 32'h0);
        check("rst_mem_data_in", 32'(bus.mem_data_in), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_dropped", 32'(bus.dropped), 32'h0);
        check("rst_best_id", 32'(bus.best_id), 32'h0);
        check("rst_best_q", 32'(bus.best_qvalue), 32'hFFFF);
        check("rst_count", 32'(bus.neighbor_count), 32'h0);
        reset = 1'b0;

        // Empty table: append into slot 0.
        clear_table(16'd0);
        exp_wr(16'h0102, 16'd4); exp_wr(16'h0104, 16'd3); exp_wr(16'h0100, 16'd1);
        run_op("empty", 16'd4, 16'd3, 6, 1'b0, 16'd4, 16'd3, 16'd1, 1'b0);

        // Hit on entry 0.
        clear_table(16'd2); put_entry(0, 16'd4, 16'd5); put_entry(1, 16'd7, 16'd2);
        exp_wr(16'h0104, 16'd20);
        run_op("hit", 16'd4, 16'd20, 10, 1'b0, 16'd7, 16'd2, 16'd2, 1'b0);

        // Miss: append as entry 2, new best.
        clear_table(16'd2); put_entry(0, 16'd4, 16'd5); put_entry(1, 16'd7, 16'd2);
        exp_wr(16'h010A, 16'd9); exp_wr(16'h010C, 16'd1); exp_wr(16'h0100, 16'd3);
        run_op("append", 16'd9, 16'd1, 12, 1'b0, 16'd9, 16'd1, 16'd3, 1'b0);

        // Full table miss: dropped, with a start pulse mid-scan that must be ignored.
        clear_table(16'd8);
        for (int i = 0; i < 8; i++) put_entry(i, W'(100 + i), W'(10 + i));
        run_op("full", 16'd50, 16'd0, 27, 1'b1, 16'd100, 16'd10, 16'd8, 1'b1);

        // Corrupt count 10 clamps to 8; hit on entry 3, count word untouched.
        clear_table(16'd10);
        for (int i = 0; i < 8; i++) put_entry(i, W'(100 + i), W'(10 + i));
        exp_wr(16'h0110, 16'd1);
        run_op("clamp", 16'd103, 16'd1, 28, 1'b0, 16'd103, 16'd1, 16'd8, 1'b0);
        check("clamp_count_word", 32'(mem[128]), 32'd10);

        // Tie: appended entry equals best, earlier entry stays best.
        clear_table(16'd1); put_entry(0, 16'd4, 16'd3);
        exp_wr(16'h0106, 16'd6); exp_wr(16'h0108, 16'd3); exp_wr(16'h0100, 16'd2);
        run_op("tie", 16'd6, 16'd3, 9, 1'b0, 16'd4, 16'd3, 16'd2, 1'b0);

        // Duplicate IDs: only the first is rewritten, the second competes with stored Q.
        clear_table(16'd2); put_entry(0, 16'd4, 16'd5); put_entry(1, 16'd4, 16'd2);
        exp_wr(16'h0104, 16'd9);
        run_op("dup", 16'd4, 16'd9, 10, 1'b0, 16'd4, 16'd2, 16'd2, 1'b0);

        // Start held high: second operation starts in the cycle after DONE.
        clear_table(16'd1); put_entry(0, 16'd4, 16'd5);
        exp_wr(16'h0104, 16'd7); exp_wr(16'h0104, 16'd7);
        target = done_count + 2;
        @(negedge clock);
        pl_we         = 1'b0;
        bus.nb_id     = 16'd4;
        bus.nb_qvalue = 16'd7;
        bus.start     = 1'b1;
        push_exp("held1", cycle + 7, 1'b0, 16'd4, 16'd7, 16'd1, 1);
        push_exp("held2", cycle + 15, 1'b0, 16'd4, 16'd7, 16'd1, 0);
        repeat (9) @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_dones("held", target);

        // Reset while in APPEND_Q: write enable drops at once, count unchanged.
        clear_table(16'd1); put_entry(0, 16'd4, 16'd3);
        exp_wr(16'h0106, 16'd9);
        @(negedge clock);
        pl_we         = 1'b0;
        bus.nb_id     = 16'd9;
        bus.nb_qvalue = 16'd2;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("rstmid_wr_en_before", 32'(bus.wr_en), 32'd1);
        check("rstmid_addr_before", 32'(bus.address), 32'h0108);
        reset = 1'b1;
        #1;
        check("rstmid_wr_en", 32'(bus.wr_en), 32'd0);
        check("rstmid_address", 32'(bus.address), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_best_q", 32'(bus.best_qvalue), 32'hFFFF);
        @(negedge clock);
        check("rstmid_count_word", 32'(mem[128]), 32'd1);
        check("rstmid_writes_left", 32'(exp_wr_q.size()), 32'd0);
        reset = 1'b0;

        // Recovery: the same upsert completes normally over the stale slot.
        exp_wr(16'h0106, 16'd9); exp_wr(16'h0108, 16'd2); exp_wr(16'h0100, 16'd2);
        run_op("recover", 16'd9, 16'd2, 9, 1'b0, 16'd9, 16'd2, 16'd2, 1'b0);

        repeat (3) @(negedge clock);
        check("end_pending_done", 32'(exp_q.size()), 32'd0);
        check("end_pending_writes", 32'(exp_wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
